// File: rtl/mem_pkg.sv
// Shared widths, FSM encoding and command/tag records for the port-B arbiter.
// Combinational logic only; no latency and no backpressure of its own.
package mem_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_STALL = STALL
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not granted last.
// Zero latency; enable=0 suppresses every grant.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic enable,
  output logic gnt0,
  output logic gnt1,
  output logic any
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign any = gnt0 | gnt1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates memory port B between two requesters; command on the bus 1 cycle after ack, read data 2 cycles after ack.
// A port-B write hitting a same-cycle port-A write to its address is held (no acks) until it can execute.
module mem_port_arbiter
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out,
  input  logic                  porta_we,
  input  logic [ADDR_WIDTH-1:0] porta_addr,
  output logic                  last_grant
);

  state_t state_q, state_d;
  cmd_t   cmd_q, win_cmd;
  tag_t   tag1_q, tag2_q;
  logic   last_grant_q;
  logic   on_bus, collision;
  logic   gnt0, gnt1, any;

  assign on_bus    = (state_q != ST_IDLE);
  assign collision = on_bus && cmd_q.we && porta_we && (porta_addr == cmd_q.addr);

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .enable     (~collision),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .any        (any)
  );

  always_comb begin
    win_cmd = '{we: we0, addr: addr0, data: wdata0};
    if (gnt1) win_cmd = '{we: we1, addr: addr1, data: wdata1};
  end

  always_comb begin
    state_d = ST_IDLE;
    if (collision)
      state_d = ST_STALL;
    else if (any)
      state_d = ST_ISSUE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      last_grant_q <= 1'b1;
      tag1_q       <= '0;
      tag2_q       <= '0;
    end else begin
      state_q <= state_d;
      // Only reads enter the tag pipe; a stalled cycle grants nothing, so it inserts a bubble.
      tag1_q  <= '{vld: any && !win_cmd.we, id: gnt1};
      tag2_q  <= tag1_q;
      if (!collision) begin
        if (any) begin
          cmd_q        <= win_cmd;
          last_grant_q <= gnt1;
        end else begin
          cmd_q.we <= 1'b0;
        end
      end
    end
  end

  assign ack0       = gnt0;
  assign ack1       = gnt1;
  assign mem_addr   = cmd_q.addr;
  assign mem_data   = cmd_q.data;
  assign mem_we     = cmd_q.we && !collision;
  assign rvalid0    = tag2_q.vld && !tag2_q.id;
  assign rvalid1    = tag2_q.vld && tag2_q.id;
  assign rdata0     = mem_out;
  assign rdata1     = mem_out;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed stall/reset sequences, randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_out;
  logic        porta_we;
  logic [9:0]  porta_addr;
  logic [15:0] porta_data;
  logic        last_grant;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_out    (mem_out),
    .porta_we   (porta_we),
    .porta_addr (porta_addr),
    .last_grant (last_grant)
  );

  // Dual-port memory: synchronous read-first port B, write-only port A.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (porta_we) mem[porta_addr] <= porta_data;
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    porta_we = 1'b0; porta_addr = '0; porta_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [9:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        pa_we;
    logic [9:0]  pa_addr;
    logic        e_ack0, e_ack1, e_mwe, e_lg, e_rv0, e_rv1;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vt [13];

  // Transaction-level model state for the randomized phase.
  logic        h_vld [2];
  logic        h_we  [2];
  logic [9:0]  h_addr[2];
  logic [15:0] h_dat [2];
  logic [15:0] gold  [0:1023];
  logic        m_last, pw_vld, bus_vld, bus_id, rv_vld, rv_id;
  logic [9:0]  pw_addr, bus_addr;
  logic [15:0] pw_dat, rv_dat;
  logic        stall, exp_we, g0, g1, w;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

    //               r0   r1   w0   w1   a0     a1     d0        d1      pawe pa_addr  ack0 ack1 mwe  lg   rv0  rv1  rdata
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h1, 10'h2, 16'h0,    16'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h1, 10'h2, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h1, 10'h2, 16'h0,    16'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h1, 10'h2, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h0, 10'h0, 16'hFEFE, 16'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFEFE};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h3, 10'h0, 16'h1234, 16'h0, 1'b1, 10'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b1, 10'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h3, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0,    16'h0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};

    do_reset();
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data", mem_data, 0);
    chk("reset rvalid0", rvalid0, 0);
    chk("reset rvalid1", rvalid1, 0);
    chk("reset last_grant", last_grant, 1);

    // Vector table: contention, write-then-read, non-colliding port-A write.
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      req0 = vt[i].r0; req1 = vt[i].r1; we0 = vt[i].w0; we1 = vt[i].w1;
      addr0 = vt[i].a0; addr1 = vt[i].a1; wdata0 = vt[i].d0; wdata1 = vt[i].d1;
      porta_we = vt[i].pa_we; porta_addr = vt[i].pa_addr; porta_data = 16'h5555;
      @(negedge clk);
      chk($sformatf("v%0d ack0", i), ack0, vt[i].e_ack0);
      chk($sformatf("v%0d ack1", i), ack1, vt[i].e_ack1);
      chk($sformatf("v%0d mem_we", i), mem_we, vt[i].e_mwe);
      chk($sformatf("v%0d last_grant", i), last_grant, vt[i].e_lg);
      chk($sformatf("v%0d rvalid0", i), rvalid0, vt[i].e_rv0);
      chk($sformatf("v%0d rvalid1", i), rvalid1, vt[i].e_rv1);
      if (vt[i].e_rv0) chk($sformatf("v%0d rdata0", i), rdata0, vt[i].e_rdata);
      if (vt[i].e_rv1) chk($sformatf("v%0d rdata1", i), rdata1, vt[i].e_rdata);
    end

    // Collided write: r1 writes 0xDEAD @2, port A writes 0xBEAF @2 while it is on the bus.
    next_cycle();
    idle_inputs();
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h2; wdata1 = 16'hDEAD;
    @(negedge clk);
    chk("col accept ack1", ack1, 1);
    next_cycle();
    idle_inputs();
    req0 = 1'b1; addr0 = 10'h2;
    porta_we = 1'b1; porta_addr = 10'h2; porta_data = 16'hBEAF;
    @(negedge clk);
    chk("col stall mem_we", mem_we, 0);
    chk("col stall ack0", ack0, 0);
    chk("col stall ack1", ack1, 0);
    next_cycle();
    porta_we = 1'b0;
    @(negedge clk);
    chk("col retry mem_we", mem_we, 1);
    chk("col retry mem_addr", mem_addr, 10'h2);
    chk("col retry mem_data", mem_data, 16'hDEAD);
    chk("col retry ack0", ack0, 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk("col read rvalid0", rvalid0, 1);
    chk("col read rvalid1", rvalid1, 0);
    chk("col read rdata0", rdata0, 16'hDEAD);

    // Reset right after a read accept drops the read and restores r0 priority.
    next_cycle();
    req0 = 1'b1; addr0 = 10'h0;
    @(negedge clk);
    chk("rst read ack0", ack0, 1);
    next_cycle();
    req0 = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst rvalid0", rvalid0, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst last_grant", last_grant, 1);
    next_cycle();
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'h1; addr1 = 10'h2;
    @(negedge clk);
    chk("rst contention ack0", ack0, 1);
    chk("rst contention ack1", ack1, 0);

    // Reset while a collided write is stalled discards that write.
    next_cycle();
    idle_inputs();
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h5; wdata1 = 16'h0077;
    @(negedge clk);
    chk("stallrst ack1", ack1, 1);
    next_cycle();
    idle_inputs();
    porta_we = 1'b1; porta_addr = 10'h5; porta_data = 16'h1111;
    reset = 1'b1;
    @(negedge clk);
    chk("stallrst collided mem_we", mem_we, 0);
    next_cycle();
    reset = 1'b0;
    porta_we = 1'b0;
    @(negedge clk);
    chk("stallrst after mem_we", mem_we, 0);
    next_cycle();
    req0 = 1'b1; addr0 = 10'h5;
    @(negedge clk);
    chk("stallrst read ack0", ack0, 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk("stallrst rvalid0", rvalid0, 1);
    chk("stallrst rdata0", rdata0, 16'h1111);

    // Randomized run against the transaction-level model.
    do_reset();
    for (int i = 0; i < 1024; i++) gold[i] = mem[i];
    for (int r = 0; r < 2; r++) h_vld[r] = 1'b0;
    m_last = 1'b1; pw_vld = 1'b0; bus_vld = 1'b0; rv_vld = 1'b0;
    pw_addr = '0; pw_dat = '0; bus_id = 1'b0; bus_addr = '0; rv_id = 1'b0; rv_dat = '0;
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      for (int r = 0; r < 2; r++) begin
        if (!h_vld[r] && ($urandom_range(0, 1) == 1)) begin
          h_vld[r]  = 1'b1;
          h_we[r]   = ($urandom_range(0, 1) == 1);
          h_addr[r] = 10'($urandom_range(0, 7));
          h_dat[r]  = 16'($urandom);
        end
      end
      req0 = h_vld[0]; we0 = h_we[0]; addr0 = h_addr[0]; wdata0 = h_dat[0];
      req1 = h_vld[1]; we1 = h_we[1]; addr1 = h_addr[1]; wdata1 = h_dat[1];
      porta_we   = ($urandom_range(0, 2) == 0);
      porta_addr = 10'($urandom_range(0, 7));
      porta_data = 16'($urandom);
      @(negedge clk);

      stall  = pw_vld && porta_we && (porta_addr == pw_addr);
      exp_we = pw_vld && !stall;
      g0 = 1'b0; g1 = 1'b0;
      if (!stall) begin
        if (h_vld[0] && h_vld[1]) begin
          g0 = m_last; g1 = !m_last;
        end else begin
          g0 = h_vld[0]; g1 = h_vld[1];
        end
      end
      chk("rnd ack0", ack0, g0);
      chk("rnd ack1", ack1, g1);
      chk("rnd mem_we", mem_we, exp_we);
      chk("rnd last_grant", last_grant, m_last);
      if (exp_we) begin
        chk("rnd mem_addr", mem_addr, pw_addr);
        chk("rnd mem_data", mem_data, pw_dat);
      end
      chk("rnd rvalid0", rvalid0, rv_vld && !rv_id);
      chk("rnd rvalid1", rvalid1, rv_vld && rv_id);
      if (rv_vld) chk("rnd rdata", rv_id ? rdata1 : rdata0, rv_dat);

      // A read on the bus sees memory as it stood before this cycle's writes land.
      rv_vld = bus_vld; rv_id = bus_id; rv_dat = gold[bus_addr];
      if (porta_we) gold[porta_addr] = porta_data;
      if (exp_we) begin
        gold[pw_addr] = pw_dat;
        pw_vld = 1'b0;
      end
      bus_vld = 1'b0;
      if (g0 || g1) begin
        w = g1;
        m_last = w;
        if (h_we[w]) begin
          pw_vld = 1'b1; pw_addr = h_addr[w]; pw_dat = h_dat[w];
        end else begin
          bus_vld = 1'b1; bus_id = w; bus_addr = h_addr[w];
        end
        h_vld[w] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares port B of the 16-bit × 1024-word dual-port `Memory` between two requesters: r0, the CPU load/store unit, and r1, the DMA/VGA fetch engine. Port A stays private to instruction fetch. The block accepts one command per cycle under round-robin arbitration and registers it onto the memory port. It returns read data tagged to the requester that issued it. It also defers port-B writes that collide with a same-cycle port-A write to the same address.

## Interface
- `DATA_WIDTH`, 16, memory word width
- `ADDR_WIDTH`, 10, memory address width

- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `req0`/`req1`  in  1  command request; held with its command until `ackN`
- `we0`/`we1`  in  1  1 = write, 0 = read
- `addr0`/`addr1`  in  ADDR_WIDTH  command address
- `wdata0`/`wdata1`  in  DATA_WIDTH  write data
- `ack0`/`ack1`  out  1  combinational; command accepted this cycle
- `rvalid0`/`rvalid1`  out  1  read data for requester N valid this cycle
- `rdata0`/`rdata1`  out  DATA_WIDTH  read data; equals `mem_out` in every cycle
- `mem_addr`  out  ADDR_WIDTH  to `addr_b`, registered
- `mem_data`  out  DATA_WIDTH  to `data_b`, registered
- `mem_we`  out  1  to `we_b`; registered write flag gated by collision
- `mem_out`  in  DATA_WIDTH  from `out_b`
- `porta_we`  in  1  port-A write enable, same cycle as at the memory
- `porta_addr`  in  ADDR_WIDTH  port-A address
- `last_grant`  out  1  requester most recently granted

## Operation
- FSM states:
  - IDLE: no command on the memory bus.
  - ISSUE: the registered command executes this cycle.
  - STALL: a collided write is being retried.
- Grant, combinational in IDLE or ISSUE (when no collision):
  - Only one `reqN` high: that requester wins.
  - Both high: the requester ≠ `last_grant` wins.
  - Winner gets `ackN`=1. At the next edge its we/addr/wdata load into the command register, `last_grant` updates, and the state goes to ISSUE.
  - No request: the state goes to IDLE and the registered we clears.
- Collision: in ISSUE, registered we=1 && `porta_we` && `porta_addr`==`mem_addr`.
  - `mem_we` is forced 0.
  - `ack0`/`ack1` are forced 0.
  - Next state is STALL with the command held.
- STALL behaves as ISSUE with the same command: the collision check is re-applied and no new grant is made until the write has executed.
- Read colliding with a port-A write: no stall; returns the memory's read-during-write value.
- Read tag: a 2-stage shift register carries (valid, id) from the grant. `rvalidN` = stage2 valid && id==N.
- Writes produce no rvalid.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `rvalid0`=`rvalid1`=0; read tags cleared.
  - `last_grant`=1, so r0 wins first contention.
  - State = IDLE.
- Reset mid-operation: any in-flight read is dropped (no rvalid) and any pending STALL write is discarded.

## Timing
- Accept at cycle T (`ackN`=1). The command is on the memory bus during T+1.
- Read data: `rvalidN`=1 with `rdataN` valid in T+2. Read latency is 2 cycles from accept.
- Write takes effect at edge end-of-T+1, or one cycle later per STALL cycle.
- Throughput: one command per cycle when there is no collision; back-to-back grants to the same requester are allowed.
- Continuous contention alternates 0,1,0,1. Worst-case wait is 1 cycle plus stall cycles.
- A STALL delays the read tag pipeline only for the stalled command's successors, because reads never stall.
- Stall length is unbounded if port A writes the same address every cycle. This is a system-level guarantee, not checked here.

## Structure
- Shared package or include `mem_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, and the FSM state encoding localparams (IDLE=2'd0, ISSUE=2'd1, STALL=2'd2).
- One sub-module: `rr_pick2`, a 2-way round-robin picker.
  - Inputs: `req0`, `req1`, `last_grant`, `enable`.
  - Outputs: `gnt0`, `gnt1`, `any`.
- Everything else (FSM, command register, tag pipe, collision compare) is in the top module.

## Test plan
- r0 writes 0xFEFE @0x000, then reads @0x000. Required: `ack0` in the accept cycle, `rvalid0`=1 with `rdata0`=0xFEFE exactly 2 cycles after the read accept, `rvalid1`=0.
- Both requesters hold reads of 0x001 (r0) and 0x002 (r1) for 4 cycles after reset. Required: grants r0,r1,r0,r1 and `last_grant` toggles each cycle.
- r1 writes 0xDEAD @0x002 while port A writes 0xBEAF @0x002 in the command cycle. Required: `mem_we`=0 and no ack for 1 cycle (STALL). Then `mem_we`=1; a later read of 0x002 returns 0xDEAD.
- r0 writes @0x003 while port A writes @0x004. Required: no stall, write executes in T+1.
- r0 read accepted, reset asserted the following cycle. Required: no `rvalid0`, `mem_we`=0, state IDLE; the next contention grants r0.
